// File: rtl/io_bus_master_if.sv
// Request/response handshake, bus address/strobe and interrupt signals
// shared between the CPU-side bus master and its environment.
// The bidirectional data bus stays a plain inout on the master itself.
interface io_bus_master_if #(
  parameter int DBITS   = 32,
  parameter int NUM_IRQ = 4
) ();
  logic               req_valid;
  logic               req_we;
  logic [DBITS-1:0]   req_addr;
  logic [DBITS-1:0]   req_wdata;
  logic               req_ready;
  logic               rsp_valid;
  logic [DBITS-1:0]   rsp_rdata;
  logic               rsp_err;
  logic [DBITS-1:0]   abus;
  logic               we;
  logic [NUM_IRQ-1:0] irq_in;
  logic               irq_en;
  logic               irq_req;
  logic [1:0]         irq_cause;
  logic               irq_ack;

  modport master (
    input  req_valid, req_we, req_addr, req_wdata, irq_in, irq_en, irq_ack,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, abus, we, irq_req, irq_cause
  );

  modport slave (
    output req_valid, req_we, req_addr, req_wdata, irq_in, irq_en, irq_ack,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, abus, we, irq_req, irq_cause
  );
endinterface

// File: rtl/io_bus_master.sv
// CPU-side initiator for the memory-mapped I/O bus: one bus cycle per
// load/store request, plus a prioritized, latched interrupt request.
//
// state  | meaning
// IDLE   | ready for a request; latches it when req_valid is high
// ACCESS | bus cycle on abus/we/dbus (I/O addresses only); load data captured
// RESP   | one-cycle rsp_valid with captured data / error flag
module io_bus_master #(
  parameter int         DBITS   = 32,
  parameter logic [3:0] IO_HI   = 4'hF,
  parameter int         NUM_IRQ = 4
) (
  input  logic             clk,
  input  logic             init,
  io_bus_master_if.master  bus,
  inout  wire [DBITS-1:0]  dbus
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t           state;
  state_t           state_nxt;
  logic             lat_we;
  logic [DBITS-1:0] lat_addr;
  logic [DBITS-1:0] lat_wdata;
  logic [DBITS-1:0] rdata_q;
  logic             err_q;
  logic             io_hit;
  logic             drive;

  logic             irq_req_q;
  logic [1:0]       irq_cause_q;
  logic             ack_d;
  logic [1:0]       irq_enc;
  logic             irq_eval;

  assign io_hit = (lat_addr[DBITS-1:DBITS-4] == IO_HI);

  // Data bus is only driven while a store to an I/O address is on the bus.
  assign dbus = drive ? lat_wdata : {DBITS{1'bz}};

  // State register; init drops any transaction in flight.
  always_ff @(posedge clk) begin
    if (init) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic: fixed three-cycle walk per request.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.req_valid) state_nxt = ACCESS;
      ACCESS:  state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic: bus idles at abus=0, we=0, dbus released outside ACCESS.
  always_comb begin
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    bus.rsp_rdata = '0;
    bus.rsp_err   = 1'b0;
    bus.abus      = '0;
    bus.we        = 1'b0;
    drive         = 1'b0;
    case (state)
      IDLE: bus.req_ready = 1'b1;
      ACCESS: begin
        if (io_hit) begin
          bus.abus = lat_addr;
          bus.we   = lat_we;
          drive    = lat_we;
        end
      end
      RESP: begin
        bus.rsp_valid = 1'b1;
        bus.rsp_rdata = rdata_q;
        bus.rsp_err   = err_q;
      end
      default: ;
    endcase
  end

  // Request latch and response capture; devices answer combinationally in ACCESS.
  always_ff @(posedge clk) begin
    if (init) begin
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            lat_we    <= bus.req_we;
            lat_addr  <= bus.req_addr;
            lat_wdata <= bus.req_wdata;
          end
        end
        ACCESS: begin
          err_q   <= ~io_hit;
          rdata_q <= (io_hit && !lat_we) ? dbus : '0;
        end
        default: ;
      endcase
    end
  end

  // Lowest-index active line wins.
  always_comb begin
    irq_enc = 2'd0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (bus.irq_in[i]) irq_enc = 2'(i);
    end
  end

  // The cycle right after an accepted ack is skipped so irq_req stays low two cycles.
  assign irq_eval = !irq_req_q && bus.irq_en && (|bus.irq_in) && !ack_d;

  // Interrupt request latch; cause is frozen while the request is up.
  always_ff @(posedge clk) begin
    if (init) begin
      irq_req_q   <= 1'b0;
      irq_cause_q <= 2'd0;
      ack_d       <= 1'b0;
    end else begin
      ack_d <= irq_req_q && bus.irq_ack;
      if (irq_req_q) begin
        if (bus.irq_ack || !bus.irq_en) irq_req_q <= 1'b0;
      end else if (irq_eval) begin
        irq_req_q   <= 1'b1;
        irq_cause_q <= irq_enc;
      end
    end
  end

  assign bus.irq_req   = irq_req_q;
  assign bus.irq_cause = irq_cause_q;

endmodule

// File: tb/tb_io_bus_master.sv
// Directed bench for io_bus_master: a table of single bus transactions
// plus hand-written interrupt, back-to-back and mid-transaction reset sequences.
module tb_io_bus_master;
  localparam int DBITS = 32;

  logic             clk = 1'b0;
  logic             init;
  wire  [DBITS-1:0] dbus;
  logic             dev_en;
  logic [DBITS-1:0] dev_addr;
  logic [DBITS-1:0] dev_data;

  int errors = 0;
  int checks = 0;

  io_bus_master_if #(.DBITS(DBITS), .NUM_IRQ(4)) bus ();

  io_bus_master #(.DBITS(DBITS), .IO_HI(4'hF), .NUM_IRQ(4)) dut (
    .clk  (clk),
    .init (init),
    .bus  (bus.master),
    .dbus (dbus)
  );

  // Device model: answers loads combinationally when the bus address matches.
  assign dbus = (dev_en && !bus.we && (bus.abus == dev_addr)) ? dev_data : {DBITS{1'bz}};

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Released bus reads Z in four-state simulators and 0 in two-state ones.
  task automatic chk_rel(input string name);
    checks++;
    if (!($isunknown(dbus) || dbus == '0)) begin
      errors++;
      $display("FAIL %s: dbus=%h expected released", name, dbus);
    end
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] dev;
    logic        exp_err;
    logic [31:0] exp_abus;
    logic        exp_we;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[6];

  initial begin
    //          we    addr          wdata         dev           err   abus          we    rdata
    vecs[0] = '{1'b1, 32'hF0000024, 32'h0000000A, 32'h0,        1'b0, 32'hF0000024, 1'b1, 32'h0};
    vecs[1] = '{1'b0, 32'hF0000020, 32'h11112222, 32'h00000007, 1'b0, 32'hF0000020, 1'b0, 32'h00000007};
    vecs[2] = '{1'b0, 32'h00001000, 32'h12345678, 32'h99999999, 1'b1, 32'h0,        1'b0, 32'h0};
    vecs[3] = '{1'b1, 32'h00002000, 32'h00000055, 32'h0,        1'b1, 32'h0,        1'b0, 32'h0};
    vecs[4] = '{1'b0, 32'hF0000100, 32'hA5A5A5A5, 32'hDEADBEEF, 1'b0, 32'hF0000100, 1'b0, 32'hDEADBEEF};
    vecs[5] = '{1'b1, 32'hFFFFFFFC, 32'h80000001, 32'h0,        1'b0, 32'hFFFFFFFC, 1'b1, 32'h0};

    init          = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.irq_in    = '0;
    bus.irq_en    = 1'b0;
    bus.irq_ack   = 1'b0;
    dev_en        = 1'b0;
    dev_addr      = '0;
    dev_data      = '0;

    step();
    step();
    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
    chk("rst_rsp_err",   32'(bus.rsp_err), 32'd0);
    chk("rst_abus",      bus.abus, 32'h0);
    chk("rst_we",        32'(bus.we), 32'd0);
    chk("rst_irq_req",   32'(bus.irq_req), 32'd0);
    chk("rst_irq_cause", 32'(bus.irq_cause), 32'd0);
    chk_rel("rst_dbus");
    init = 1'b0;
    step();

    // Table of single transactions.
    for (int k = 0; k < 6; k++) begin
      dev_addr = vecs[k].addr;
      dev_data = vecs[k].dev;
      dev_en   = !vecs[k].we;
      chk($sformatf("v%0d_ready_n", k), 32'(bus.req_ready), 32'd1);
      bus.req_valid = 1'b1;
      bus.req_we    = vecs[k].we;
      bus.req_addr  = vecs[k].addr;
      bus.req_wdata = vecs[k].wdata;
      step();
      bus.req_valid = 1'b0;
      bus.req_addr  = 32'hF0000020;
      bus.req_wdata = 32'hCAFEF00D;
      chk($sformatf("v%0d_ready_n1", k), 32'(bus.req_ready), 32'd0);
      chk($sformatf("v%0d_abus_n1", k), bus.abus, vecs[k].exp_abus);
      chk($sformatf("v%0d_we_n1", k), 32'(bus.we), 32'(vecs[k].exp_we));
      chk($sformatf("v%0d_rsp_valid_n1", k), 32'(bus.rsp_valid), 32'd0);
      if (vecs[k].we && !vecs[k].exp_err) chk($sformatf("v%0d_dbus_n1", k), dbus, vecs[k].wdata);
      else if (vecs[k].we || vecs[k].exp_err) chk_rel($sformatf("v%0d_dbus_n1", k));
      step();
      chk($sformatf("v%0d_rsp_valid_n2", k), 32'(bus.rsp_valid), 32'd1);
      chk($sformatf("v%0d_rsp_err_n2", k), 32'(bus.rsp_err), 32'(vecs[k].exp_err));
      chk($sformatf("v%0d_rsp_rdata_n2", k), bus.rsp_rdata, vecs[k].exp_rdata);
      chk($sformatf("v%0d_ready_n2", k), 32'(bus.req_ready), 32'd0);
      chk($sformatf("v%0d_we_n2", k), 32'(bus.we), 32'd0);
      chk($sformatf("v%0d_abus_n2", k), bus.abus, 32'h0);
      chk_rel($sformatf("v%0d_dbus_n2", k));
      step();
      chk($sformatf("v%0d_ready_n3", k), 32'(bus.req_ready), 32'd1);
      chk($sformatf("v%0d_rsp_valid_n3", k), 32'(bus.rsp_valid), 32'd0);
      chk($sformatf("v%0d_we_n3", k), 32'(bus.we), 32'd0);
    end

    // Back-to-back loads with req_valid held: one request per three cycles.
    dev_addr      = 32'hF0000020;
    dev_data      = 32'h00000007;
    dev_en        = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_addr  = 32'hF0000020;
    step();
    chk("b2b_rsp_valid_n1", 32'(bus.rsp_valid), 32'd0);
    step();
    chk("b2b_rsp_valid_n2", 32'(bus.rsp_valid), 32'd1);
    chk("b2b_rdata_n2", bus.rsp_rdata, 32'h00000007);
    step();
    chk("b2b_ready_n3", 32'(bus.req_ready), 32'd1);
    chk("b2b_rsp_valid_n3", 32'(bus.rsp_valid), 32'd0);
    step();
    bus.req_valid = 1'b0;
    chk("b2b_ready_n4", 32'(bus.req_ready), 32'd0);
    step();
    chk("b2b_rsp_valid_n5", 32'(bus.rsp_valid), 32'd1);
    step();
    dev_en = 1'b0;

    // Interrupt priority, frozen cause, ack gap.
    bus.irq_en = 1'b1;
    bus.irq_in = 4'b0110;
    chk("irq_idle", 32'(bus.irq_req), 32'd0);
    step();
    chk("irq_raise_req", 32'(bus.irq_req), 32'd1);
    chk("irq_raise_cause", 32'(bus.irq_cause), 32'd1);
    bus.irq_in = 4'b0001;
    step();
    chk("irq_frozen_req", 32'(bus.irq_req), 32'd1);
    chk("irq_frozen_cause", 32'(bus.irq_cause), 32'd1);
    bus.irq_ack = 1'b1;
    step();
    bus.irq_ack = 1'b0;
    chk("irq_ack_low1", 32'(bus.irq_req), 32'd0);
    step();
    chk("irq_ack_low2", 32'(bus.irq_req), 32'd0);
    step();
    chk("irq_reraise_req", 32'(bus.irq_req), 32'd1);
    chk("irq_reraise_cause", 32'(bus.irq_cause), 32'd0);

    // Enable withdrawn while requesting.
    bus.irq_en = 1'b0;
    step();
    chk("irq_en_drop", 32'(bus.irq_req), 32'd0);
    for (int c = 0; c < 3; c++) begin
      step();
      chk($sformatf("irq_en_off_c%0d", c), 32'(bus.irq_req), 32'd0);
    end

    // Reset in the ACCESS cycle of a store, with an interrupt pending.
    bus.irq_en    = 1'b1;
    bus.irq_in    = 4'b0100;
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_addr  = 32'hF0000030;
    bus.req_wdata = 32'h00001234;
    step();
    bus.req_valid = 1'b0;
    chk("rstmid_we_n1", 32'(bus.we), 32'd1);
    chk("rstmid_dbus_n1", dbus, 32'h00001234);
    chk("rstmid_irq_req", 32'(bus.irq_req), 32'd1);
    chk("rstmid_irq_cause", 32'(bus.irq_cause), 32'd2);
    init = 1'b1;
    step();
    init = 1'b0;
    chk("rstmid_we", 32'(bus.we), 32'd0);
    chk("rstmid_abus", bus.abus, 32'h0);
    chk_rel("rstmid_dbus");
    chk("rstmid_ready", 32'(bus.req_ready), 32'd1);
    chk("rstmid_irq_cleared", 32'(bus.irq_req), 32'd0);
    chk("rstmid_cause_cleared", 32'(bus.irq_cause), 32'd0);
    chk("rstmid_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    for (int c = 0; c < 5; c++) begin
      step();
      chk($sformatf("rstmid_no_rsp_c%0d", c), 32'(bus.rsp_valid), 32'd0);
      chk($sformatf("rstmid_no_we_c%0d", c), 32'(bus.we), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
